// File: rtl/noc_link_arbiter.sv
// Round-robin, packet-locked arbiter sharing one NoC link among NUM_REQ flit sources.
// Grant is held until the last flit (or MAX_FLITS) is accepted; output is a registered stage.
module noc_link_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_FLITS = 16,
  localparam int GW = $clog2(NUM_REQ),
  localparam int CW = $clog2(MAX_FLITS + 1)
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         net_data_out,
  output logic                      net_valid_out,
  output logic                      net_last_out,
  input  logic                      net_ready_in,
  output logic [GW-1:0]             grant_id,
  output logic                      busy,
  output logic                      err_overlen
);

  localparam logic IDLE = 1'b0;
  localparam logic LOCK = 1'b1;

  logic              r_state;
  logic [GW-1:0]     r_rr_ptr;
  logic [GW-1:0]     r_grant;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_last;
  logic              r_err;

  logic              w_slot_free;
  logic              w_sel_valid;
  logic              w_sel_last;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_acc;
  logic              w_max_hit;
  logic              w_rel;
  logic              w_win_found;
  logic [GW-1:0]     w_win_idx;

  assign w_slot_free = !r_valid || net_ready_in;
  assign w_sel_valid = req_valid[r_grant];
  assign w_sel_last  = req_last[r_grant];
  assign w_sel_data  = req_data[r_grant*DATA_W +: DATA_W];
  assign w_acc       = (r_state == LOCK) && w_slot_free && w_sel_valid;
  assign w_max_hit   = (r_cnt == CW'(MAX_FLITS - 1));
  assign w_rel       = w_sel_last || w_max_hit;

  // First requester at or after rr_ptr, searching upward with wrap.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_win_found && req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_win_found = 1'b1;
        w_win_idx   = GW'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
    assign req_ready[i] = (r_state == LOCK) && w_slot_free && (r_grant == GW'(i));
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_acc) begin
        r_data  <= w_sel_data;
        r_valid <= 1'b1;
        r_last  <= w_rel;
        r_cnt   <= r_cnt + CW'(1);
        if (w_rel) begin
          r_state  <= IDLE;
          r_rr_ptr <= GW'((int'(r_grant) + 1) % NUM_REQ);
          r_err    <= !w_sel_last;
        end
      end else if (r_valid && net_ready_in) begin
        r_valid <= 1'b0;
      end
      // Arbitration only in IDLE; acceptance only in LOCK, so the two never collide.
      if (r_state == IDLE && w_win_found) begin
        r_state <= LOCK;
        r_grant <= w_win_idx;
        r_cnt   <= '0;
      end
    end
  end

  assign net_data_out  = r_data;
  assign net_valid_out = r_valid;
  assign net_last_out  = r_last;
  assign grant_id      = r_grant;
  assign busy          = (r_state == LOCK);
  assign err_overlen   = r_err;

endmodule
